// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a word-wide data memory.
// Sub-word stores use a read-modify-write sequence; misaligned accesses trap or are force-aligned.
module load_store_unit #(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data,
  output logic [2:0]  state
);

  // Handshake: a request is taken on the rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and resp_valid is a single-cycle pulse with no backpressure.
  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_READ, RMW_WRITE, RESP} state_t;

  state_t      st;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        fault;
  logic [31:0] addr_al;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign state = st;

  // Size 11 always faults; alignment faults only when trapping, otherwise low bits are cleared.
  always_comb begin
    addr_al = req_addr;
    fault   = (req_size == 2'b11);
    if (req_size == 2'b01) begin
      addr_al[0] = 1'b0;
      if (MISALIGN_TRAP && req_addr[0]) fault = 1'b1;
    end else if (req_size == 2'b10) begin
      addr_al[1:0] = 2'b00;
      if (MISALIGN_TRAP && (req_addr[1:0] != 2'b00)) fault = 1'b1;
    end
  end

  always_comb begin
    byte_v = mem_read_data[{lane_q, 3'b000} +: 8];
    half_v = mem_read_data[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_val = {{24{~unsigned_q & byte_v[7]}}, byte_v};
      2'b01:   load_val = {{16{~unsigned_q & half_v[15]}}, half_v};
      default: load_val = mem_read_data;
    endcase
  end

  always_comb begin
    merged = mem_read_data;
    if (size_q == 2'b00) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st              <= IDLE;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      mem_address     <= '0;
      mem_write_data  <= '0;
      mem_write       <= 1'b0;
      mem_read        <= 1'b0;
      size_q          <= '0;
      unsigned_q      <= 1'b0;
      lane_q          <= '0;
      wdata_q         <= '0;
    end else begin
      resp_valid      <= 1'b0;
      resp_misaligned <= 1'b0;
      case (st)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            lane_q     <= addr_al[1:0];
            wdata_q    <= req_wdata[15:0];
            if (fault) begin
              st              <= RESP;
              resp_valid      <= 1'b1;
              resp_misaligned <= 1'b1;
              resp_rdata      <= '0;
            end else if (!req_write) begin
              st          <= LOAD;
              mem_read    <= 1'b1;
              mem_address <= {addr_al[31:2], 2'b00};
            end else if (req_size == 2'b10) begin
              st             <= STORE;
              mem_write      <= 1'b1;
              mem_write_data <= req_wdata;
              mem_address    <= {addr_al[31:2], 2'b00};
            end else begin
              st          <= RMW_READ;
              mem_read    <= 1'b1;
              mem_address <= {addr_al[31:2], 2'b00};
            end
          end
        end
        LOAD: begin
          st          <= RESP;
          mem_read    <= 1'b0;
          mem_address <= '0;
          resp_valid  <= 1'b1;
          resp_rdata  <= load_val;
        end
        STORE: begin
          st             <= RESP;
          mem_write      <= 1'b0;
          mem_write_data <= '0;
          mem_address    <= '0;
          resp_valid     <= 1'b1;
          resp_rdata     <= '0;
        end
        RMW_READ: begin
          // Address is kept; the merged word is written back on the next cycle.
          st             <= RMW_WRITE;
          mem_read       <= 1'b0;
          mem_write      <= 1'b1;
          mem_write_data <= merged;
        end
        RMW_WRITE: begin
          st             <= RESP;
          mem_write      <= 1'b0;
          mem_write_data <= '0;
          mem_address    <= '0;
          resp_valid     <= 1'b1;
          resp_rdata     <= '0;
        end
        RESP: begin
          st        <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          st        <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
